ip_rx_hdr_chksum_check: RTL and testbench



---
 rtl/ip_chksum_pkg.sv | 24 ++
 rtl/ones_comp_beat_sum.sv | 34 +++
 rtl/ip_rx_hdr_chksum_check.sv | 184 ++++++++++++++++++
 tb/tb_ip_rx_hdr_chksum_check.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_chksum_pkg.sv
// Shared state encoding, IPv4 header constants and the checksum fold
// used by the RX header checksum checker.
package ip_chksum_pkg;

  typedef enum logic [1:0] {
    ST_SUM   = 2'd0,
    ST_RESP  = 2'd1,
    ST_DRAIN = 2'd2
  } chk_state_e;

  localparam int IP_CHKSUM_W   = 16;
  localparam int IP_MIN_IHL    = 5;
  localparam int IP_CHKSUM_OFS = 10;

  // Two end-around-carry passes; the second can no longer carry out.
  function automatic logic [IP_CHKSUM_W-1:0] fold16(input logic [31:0] acc);
    logic [16:0] s1;
    logic [16:0] s2;
    s1 = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
    s2 = {1'b0, s1[15:0]} + {16'b0, s1[16]};
    return s2[15:0];
  endfunction

endpackage

// File: rtl/ones_comp_beat_sum.sv
// Combinational partial sum of the 16-bit header words carried by one beat.
// A word with only its high byte kept contributes {byte, 8'h00}.
module ones_comp_beat_sum
  import ip_chksum_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int CNT_W      = 16
) (
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [DATA_WIDTH/8-1:0] i_keep,
  input  logic [CNT_W-1:0]        i_base,
  input  logic [7:0]              i_hdr_len,
  output logic [20:0]             o_sum
);

  localparam int KW    = DATA_WIDTH / 8;
  localparam int NW    = DATA_WIDTH / 16;
  localparam int SUM_W = 21;

  logic [IP_CHKSUM_W-1:0] w_word;

  always_comb begin
    o_sum  = '0;
    w_word = '0;
    for (int w = 0; w < NW; w++) begin
      if (i_keep[KW-1-2*w] && ((i_base + CNT_W'(2*w)) < CNT_W'(i_hdr_len))) begin
        w_word = {i_data[DATA_WIDTH-1-16*w -: 8],
                  (i_keep[KW-2-2*w] ? i_data[DATA_WIDTH-9-16*w -: 8] : 8'h00)};
        o_sum  = o_sum + {{(SUM_W-IP_CHKSUM_W){1'b0}}, w_word};
      end
    end
  end

endmodule

// File: rtl/ip_rx_hdr_chksum_check.sv
// Streaming IPv4 RX header checksum verifier: sums the IHL-sized header,
// issues one registered verdict per packet, then drains the payload.
//   state    | meaning
//   ST_SUM   | accepting header beats, accumulating in-header words
//   ST_RESP  | verdict presented, input stalled until resp_rdy
//   ST_DRAIN | discarding payload beats up to in_last
module ip_rx_hdr_chksum_check
  import ip_chksum_pkg::*;
#(
  parameter int DATA_WIDTH    = 256,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int MAX_HDR_BYTES = 60
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [KEEP_WIDTH-1:0]  in_keep,
  input  logic                   in_val,
  input  logic                   in_last,
  output logic                   in_rdy,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic [IP_CHKSUM_W-1:0] resp_sum,
  output logic [IP_CHKSUM_W-1:0] resp_rx_chksum,
  output logic                   resp_ok,
  output logic                   resp_len_err,
  output logic                   resp_trunc_err
);

  localparam int BPB   = DATA_WIDTH / 8;
  localparam int NW    = DATA_WIDTH / 16;
  localparam int CNT_W = 16;

  chk_state_e r_state;
  chk_state_e w_next_state;

  logic [CNT_W-1:0]       r_byte_cnt;
  logic [7:0]             r_hdr_len;
  logic [31:0]            r_acc;
  logic [IP_CHKSUM_W-1:0] r_rx_chk;
  logic                   r_last_seen;
  logic [IP_CHKSUM_W-1:0] r_resp_sum;
  logic [IP_CHKSUM_W-1:0] r_resp_chk;
  logic                   r_resp_ok;
  logic                   r_len_err;
  logic                   r_trunc_err;

  logic                   w_fire;
  logic                   w_first;
  logic [3:0]             w_ihl;
  logic [7:0]             w_live_len;
  logic [7:0]             w_hdr_len;
  logic [7:0]             w_sum_len;
  logic                   w_len_err;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_hdr_end;
  logic                   w_done;
  logic                   w_trunc;
  logic [20:0]            w_part;
  logic [31:0]            w_acc_next;
  logic [IP_CHKSUM_W-1:0] w_sum_fold;
  logic                   w_chk_hit;
  logic [IP_CHKSUM_W-1:0] w_chk_word;

  assign w_fire     = in_val && (r_state != ST_RESP);
  assign w_first    = (r_byte_cnt == '0);
  assign w_ihl      = in_data[DATA_WIDTH-5 -: 4];
  assign w_live_len = {2'b00, w_ihl, 2'b00};
  assign w_hdr_len  = w_first ? w_live_len : r_hdr_len;
  assign w_len_err  = w_first && ((w_ihl < 4'(IP_MIN_IHL)) ||
                                  (w_live_len > 8'(MAX_HDR_BYTES)));
  // A bad IHL must contribute nothing, so the beat sum sees a zero length.
  assign w_sum_len  = w_len_err ? 8'd0 : w_hdr_len;
  assign w_cnt_next = r_byte_cnt + CNT_W'(BPB);
  assign w_hdr_end  = (w_cnt_next >= CNT_W'(w_hdr_len));
  assign w_done     = w_len_err || w_hdr_end || in_last;
  assign w_trunc    = in_last && !w_hdr_end && !w_len_err;
  assign w_acc_next = r_acc + {11'b0, w_part};
  assign w_sum_fold = fold16(w_acc_next);

  ones_comp_beat_sum #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_beat_sum (
    .i_data    (in_data),
    .i_keep    (in_keep),
    .i_base    (r_byte_cnt),
    .i_hdr_len (w_sum_len),
    .o_sum     (w_part)
  );

  always_comb begin
    w_chk_hit  = 1'b0;
    w_chk_word = '0;
    for (int w = 0; w < NW; w++) begin
      if ((r_byte_cnt + CNT_W'(2*w)) == CNT_W'(IP_CHKSUM_OFS)) begin
        w_chk_hit  = !w_len_err;
        w_chk_word = in_data[DATA_WIDTH-1-16*w -: 16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_SUM;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_rdy       = 1'b0;
    resp_val     = 1'b0;
    case (r_state)
      ST_SUM: begin
        in_rdy = 1'b1;
        if (in_val && w_done) w_next_state = ST_RESP;
      end
      ST_RESP: begin
        resp_val = 1'b1;
        if (resp_rdy) w_next_state = r_last_seen ? ST_SUM : ST_DRAIN;
      end
      ST_DRAIN: begin
        in_rdy = 1'b1;
        if (in_val && in_last) w_next_state = ST_SUM;
      end
      default: w_next_state = ST_SUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_byte_cnt  <= '0;
      r_hdr_len   <= '0;
      r_acc       <= '0;
      r_rx_chk    <= '0;
      r_last_seen <= 1'b0;
      r_resp_sum  <= '0;
      r_resp_chk  <= '0;
      r_resp_ok   <= 1'b0;
      r_len_err   <= 1'b0;
      r_trunc_err <= 1'b0;
    end else begin
      case (r_state)
        ST_SUM: begin
          if (w_fire) begin
            r_byte_cnt <= w_cnt_next;
            r_acc      <= w_acc_next;
            if (w_first)   r_hdr_len <= w_live_len;
            if (w_chk_hit) r_rx_chk  <= w_chk_word;
            if (w_done) begin
              r_resp_sum  <= w_sum_fold;
              r_resp_chk  <= w_chk_hit ? w_chk_word : r_rx_chk;
              r_resp_ok   <= (w_sum_fold == 16'hFFFF) && !w_len_err && !w_trunc;
              r_len_err   <= w_len_err;
              r_trunc_err <= w_trunc;
              r_last_seen <= in_last;
            end
          end
        end
        ST_RESP: begin
          if (resp_rdy) begin
            r_byte_cnt  <= '0;
            r_hdr_len   <= '0;
            r_acc       <= '0;
            r_rx_chk    <= '0;
            r_last_seen <= 1'b0;
            r_resp_sum  <= '0;
            r_resp_chk  <= '0;
            r_resp_ok   <= 1'b0;
            r_len_err   <= 1'b0;
            r_trunc_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_sum       = r_resp_sum;
  assign resp_rx_chksum = r_resp_chk;
  assign resp_ok        = r_resp_ok;
  assign resp_len_err   = r_len_err;
  assign resp_trunc_err = r_trunc_err;

endmodule

// File: tb/tb_ip_rx_hdr_chksum_check.sv
// Bench for ip_rx_hdr_chksum_check: a 256-bit and a 64-bit instance,
// verdicts checked against a byte-level reference model through scoreboards.
module tb_ip_rx_hdr_chksum_check;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [255:0] a_data;  logic [31:0] a_keep;
  logic a_val, a_last, a_rdy, a_rval, a_rrdy, a_ok, a_lerr, a_terr;
  logic [15:0] a_sum, a_chk;

  logic [63:0] b_data;   logic [7:0] b_keep;
  logic b_val, b_last, b_rdy, b_rval, b_rrdy, b_ok, b_lerr, b_terr;
  logic [15:0] b_sum, b_chk;

  ip_rx_hdr_chksum_check #(.DATA_WIDTH(256)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_keep(a_keep),
    .in_val(a_val), .in_last(a_last), .in_rdy(a_rdy),
    .resp_val(a_rval), .resp_rdy(a_rrdy), .resp_sum(a_sum),
    .resp_rx_chksum(a_chk), .resp_ok(a_ok), .resp_len_err(a_lerr),
    .resp_trunc_err(a_terr));

  ip_rx_hdr_chksum_check #(.DATA_WIDTH(64)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_keep(b_keep),
    .in_val(b_val), .in_last(b_last), .in_rdy(b_rdy),
    .resp_val(b_rval), .resp_rdy(b_rrdy), .resp_sum(b_sum),
    .resp_rx_chksum(b_chk), .resp_ok(b_ok), .resp_len_err(b_lerr),
    .resp_trunc_err(b_terr));

  typedef struct {
    logic [15:0] sum;
    logic [15:0] chk;
    bit          chk_vld;
    bit          ok;
    bit          len_err;
    bit          trunc_err;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pb[128];
  bit         pk[128];

  localparam logic [159:0] H1 = 160'h4500_0073_0000_4000_4011_b861_c0a8_0001_c0a8_00c7;
  localparam logic [159:0] H2 = 160'h4500_0073_0000_4000_4011_b862_c0a8_0001_c0a8_00c7;

  // Reference: nrx = bytes delivered before the packet's verdict beat ended.
  function automatic exp_t model(input int nrx);
    exp_t e;
    int unsigned acc;
    int hl;
    logic [7:0] b0;
    logic [7:0] lo;
    e = '{default: '0};
    b0 = pb[0];
    hl = 4 * int'(b0[3:0]);
    if (b0[3:0] < 4'd5 || hl > 60) begin
      e.len_err = 1'b1;
      return e;
    end
    acc = 0;
    for (int o = 0; o < hl && o < nrx; o += 2) begin
      if (pk[o]) begin
        lo = (o + 1 < nrx && pk[o+1]) ? pb[o+1] : 8'h00;
        acc += {16'h0, pb[o], lo};
      end
    end
    while (acc > 32'hFFFF) acc = (acc & 32'hFFFF) + (acc >> 16);
    e.sum       = acc[15:0];
    e.trunc_err = (nrx < hl);
    e.chk_vld   = (nrx >= 12);
    e.chk       = {pb[10], pb[11]};
    e.ok        = (e.sum == 16'hFFFF) && !e.trunc_err;
    return e;
  endfunction

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n && a_rval && a_rrdy) begin
      n_tests++;
      if (sb_a.size() == 0) begin
        n_fail++;
        $display("FAIL sb_a_unexpected: verdict sum=%h with nothing expected", a_sum);
      end else begin
        e = sb_a.pop_front();
        if (a_sum !== e.sum || a_ok !== e.ok || a_lerr !== e.len_err ||
            a_terr !== e.trunc_err || (e.chk_vld && a_chk !== e.chk)) begin
          n_fail++;
          $display("FAIL sb_a_verdict: got sum=%h chk=%h ok=%b len=%b trunc=%b, want sum=%h chk=%h ok=%b len=%b trunc=%b",
                   a_sum, a_chk, a_ok, a_lerr, a_terr, e.sum, e.chk, e.ok, e.len_err, e.trunc_err);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && b_rval && b_rrdy) begin
      n_tests++;
      if (sb_b.size() == 0) begin
        n_fail++;
        $display("FAIL sb_b_unexpected: verdict sum=%h with nothing expected", b_sum);
      end else begin
        e = sb_b.pop_front();
        if (b_sum !== e.sum || b_ok !== e.ok || b_lerr !== e.len_err ||
            b_terr !== e.trunc_err || (e.chk_vld && b_chk !== e.chk)) begin
          n_fail++;
          $display("FAIL sb_b_verdict: got sum=%h chk=%h ok=%b len=%b trunc=%b, want sum=%h chk=%h ok=%b len=%b trunc=%b",
                   b_sum, b_chk, b_ok, b_lerr, b_terr, e.sum, e.chk, e.ok, e.len_err, e.trunc_err);
        end
      end
    end
  end

  task automatic set_hdr20(input logic [159:0] h);
    for (int i = 0; i < 20; i++) begin
      pb[i] = h[159-8*i -: 8];
      pk[i] = 1'b1;
    end
  endtask

  task automatic fill_payload(input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      pb[i] = 8'(i * 7 + 3);
      pk[i] = 1'b1;
    end
    for (int i = upto; i < 128; i++) begin
      pb[i] = 8'h00;
      pk[i] = 1'b0;
    end
  endtask

  task automatic fix_chksum(input int hl);
    exp_t e;
    pb[10] = 8'h00;
    pb[11] = 8'h00;
    e = model(hl);
    pb[10] = ~e.sum[15:8];
    pb[11] = ~e.sum[7:0];
  endtask

  task automatic send_beat(input bit w64, input int idx, input bit last, output int stall);
    logic [255:0] d;
    logic [31:0]  k;
    int bpb;
    bpb = w64 ? 8 : 32;
    d = '0;
    k = '0;
    stall = 0;
    for (int i = 0; i < bpb; i++) begin
      d[255-8*i -: 8] = pb[idx*bpb+i];
      k[31-i]         = pk[idx*bpb+i];
    end
    if (w64) begin
      b_data = d[255:192]; b_keep = k[31:24]; b_last = last; b_val = 1'b1;
    end else begin
      a_data = d; a_keep = k; a_last = last; a_val = 1'b1;
    end
    while (!(w64 ? b_rdy : a_rdy) && stall < 50) begin
      @(posedge clk); #1;
      stall++;
    end
    if (stall >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL beat_accept_timeout: in_rdy=0 for %0d cycles, want 1", stall);
    end else begin
      @(posedge clk); #1;
    end
    a_val = 1'b0; a_last = 1'b0;
    b_val = 1'b0; b_last = 1'b0;
  endtask

  task automatic wait_resp(input bit w64);
    int n;
    n = 0;
    while (!(w64 ? b_rval : a_rval) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL resp_timeout: resp_val=0 after %0d cycles, want 1", n);
    end
  endtask

  task automatic handshake(input bit w64);
    if (w64) b_rrdy = 1'b1; else a_rrdy = 1'b1;
    @(posedge clk); #1;
    a_rrdy = 1'b0;
    b_rrdy = 1'b0;
  endtask

  task automatic good_pkt_a();
    int st;
    set_hdr20(H1);
    fill_payload(20, 32);
    sb_a.push_back(model(32));
    send_beat(1'b0, 0, 1'b1, st);
    wait_resp(1'b0);
    handshake(1'b0);
  endtask

  task automatic test_reset();
    n_tests++;
    if (a_rdy !== 1'b1 || a_rval !== 1'b0 || {a_sum, a_chk, a_ok, a_lerr, a_terr} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_a: got rdy=%b val=%b sum=%h chk=%h flags=%b%b%b, want rdy=1 val=0 all zero",
               a_rdy, a_rval, a_sum, a_chk, a_ok, a_lerr, a_terr);
    end
    n_tests++;
    if (b_rdy !== 1'b1 || b_rval !== 1'b0 || {b_sum, b_chk, b_ok, b_lerr, b_terr} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_b: got rdy=%b val=%b sum=%h chk=%h flags=%b%b%b, want rdy=1 val=0 all zero",
               b_rdy, b_rval, b_sum, b_chk, b_ok, b_lerr, b_terr);
    end
  endtask

  task automatic test_single_beat();
    int st;
    set_hdr20(H1);
    fill_payload(20, 32);
    sb_a.push_back(model(32));
    send_beat(1'b0, 0, 1'b1, st);
    n_tests++;
    if (a_rval !== 1'b1 || a_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency: got resp_val=%b in_rdy=%b, want 1 0", a_rval, a_rdy);
    end
    n_tests++;
    if (a_sum !== 16'hFFFF || a_chk !== 16'hb861 || a_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL single_verdict: got sum=%h chk=%h ok=%b, want ffff b861 1", a_sum, a_chk, a_ok);
    end
    handshake(1'b0);
    n_tests++;
    if (a_rdy !== 1'b1 || a_rval !== 1'b0) begin
      n_fail++;
      $display("FAIL single_no_drain: got in_rdy=%b resp_val=%b, want 1 0", a_rdy, a_rval);
    end
  endtask

  task automatic test_back_to_back();
    int st;
    set_hdr20(H2);
    fill_payload(20, 32);
    sb_a.push_back(model(32));
    send_beat(1'b0, 0, 1'b1, st);
    n_tests++;
    if (st !== 0 || a_rval !== 1'b1 || a_sum !== 16'h0001) begin
      n_fail++;
      $display("FAIL b2b: got stall=%0d resp_val=%b sum=%h, want 0 1 0001", st, a_rval, a_sum);
    end
    handshake(1'b0);
  endtask

  task automatic test_bad_chksum_drain();
    int st;
    int tot;
    set_hdr20(H2);
    fill_payload(20, 128);
    sb_a.push_back(model(128));
    send_beat(1'b0, 0, 1'b0, st);
    wait_resp(1'b0);
    n_tests++;
    if (a_sum !== 16'h0001 || a_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_verdict: got sum=%h ok=%b, want 0001 0", a_sum, a_ok);
    end
    a_val = 1'b1;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (a_rdy !== 1'b0 || a_rval !== 1'b1) begin
        n_fail++;
        $display("FAIL resp_stall: got in_rdy=%b resp_val=%b, want 0 1", a_rdy, a_rval);
      end
      @(posedge clk); #1;
    end
    a_val = 1'b0;
    handshake(1'b0);
    tot = 0;
    for (int i = 1; i <= 3; i++) begin
      send_beat(1'b0, i, i == 3, st);
      tot += st;
    end
    n_tests++;
    if (tot !== 0 || a_rdy !== 1'b1 || a_rval !== 1'b0) begin
      n_fail++;
      $display("FAIL drain3: got stalls=%0d in_rdy=%b resp_val=%b, want 0 1 0", tot, a_rdy, a_rval);
    end
    good_pkt_a();
  endtask

  task automatic test_ihl6_w64();
    int st;
    set_hdr20(H1);
    fill_payload(20, 32);
    pb[0] = 8'h46;
    pb[20] = 8'h01; pb[21] = 8'h01; pb[22] = 8'h01; pb[23] = 8'h00;
    fix_chksum(24);
    sb_b.push_back(model(32));
    send_beat(1'b1, 0, 1'b0, st);
    send_beat(1'b1, 1, 1'b0, st);
    n_tests++;
    if (b_rval !== 1'b0) begin
      n_fail++;
      $display("FAIL ihl6_early: got resp_val=%b after beat 1, want 0", b_rval);
    end
    send_beat(1'b1, 2, 1'b0, st);
    n_tests++;
    if (b_rval !== 1'b1 || b_sum !== 16'hFFFF || b_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL ihl6_verdict: got val=%b sum=%h ok=%b, want 1 ffff 1", b_rval, b_sum, b_ok);
    end
    handshake(1'b1);
    send_beat(1'b1, 3, 1'b1, st);
  endtask

  task automatic test_len_err();
    int st;
    set_hdr20(H1);
    fill_payload(20, 64);
    pb[0] = 8'h44;
    sb_a.push_back(model(64));
    send_beat(1'b0, 0, 1'b0, st);
    wait_resp(1'b0);
    n_tests++;
    if (a_lerr !== 1'b1 || a_ok !== 1'b0 || a_sum !== 16'h0000) begin
      n_fail++;
      $display("FAIL len_err: got len=%b ok=%b sum=%h, want 1 0 0000", a_lerr, a_ok, a_sum);
    end
    handshake(1'b0);
    send_beat(1'b0, 1, 1'b1, st);
    good_pkt_a();
  endtask

  task automatic test_trunc_w64();
    int st;
    set_hdr20(H1);
    fill_payload(16, 16);
    pk[15] = 1'b0;
    sb_b.push_back(model(16));
    send_beat(1'b1, 0, 1'b0, st);
    send_beat(1'b1, 1, 1'b1, st);
    n_tests++;
    if (b_rval !== 1'b1 || b_terr !== 1'b1 || b_ok !== 1'b0 || b_chk !== 16'hb861) begin
      n_fail++;
      $display("FAIL trunc: got val=%b trunc=%b ok=%b chk=%h, want 1 1 0 b861", b_rval, b_terr, b_ok, b_chk);
    end
    handshake(1'b1);
    n_tests++;
    if (b_rdy !== 1'b1 || b_rval !== 1'b0) begin
      n_fail++;
      $display("FAIL trunc_after: got in_rdy=%b resp_val=%b, want 1 0", b_rdy, b_rval);
    end
    set_hdr20(H1);
    fill_payload(20, 24);
    sb_b.push_back(model(24));
    for (int i = 0; i < 3; i++) send_beat(1'b1, i, i == 2, st);
    wait_resp(1'b1);
    handshake(1'b1);
  endtask

  task automatic test_max_ihl();
    int st;
    set_hdr20(H1);
    fill_payload(20, 64);
    pb[0] = 8'h4F;
    for (int i = 20; i < 60; i++) pb[i] = 8'h01;
    for (int i = 60; i < 64; i++) pb[i] = 8'hAA;
    fix_chksum(60);
    sb_a.push_back(model(64));
    send_beat(1'b0, 0, 1'b0, st);
    n_tests++;
    if (a_rval !== 1'b0) begin
      n_fail++;
      $display("FAIL max_ihl_early: got resp_val=%b after beat 0, want 0", a_rval);
    end
    send_beat(1'b0, 1, 1'b1, st);
    n_tests++;
    if (a_rval !== 1'b1 || a_ok !== 1'b1 || a_lerr !== 1'b0) begin
      n_fail++;
      $display("FAIL max_ihl: got val=%b ok=%b len=%b, want 1 1 0", a_rval, a_ok, a_lerr);
    end
    handshake(1'b0);
  endtask

  task automatic test_reset_in_resp();
    int st;
    set_hdr20(H1);
    fill_payload(20, 64);
    send_beat(1'b0, 0, 1'b0, st);
    wait_resp(1'b0);
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_tests++;
      if (c < 5) begin
        if (a_rval !== 1'b1 || a_sum !== 16'hFFFF) begin
          n_fail++;
          $display("FAIL resp_hold: cycle %0d got val=%b sum=%h, want 1 ffff", c, a_rval, a_sum);
        end
      end else if (a_rval !== 1'b0 || a_rdy !== 1'b1 ||
                   {a_sum, a_chk, a_ok, a_lerr, a_terr} !== 35'd0) begin
        n_fail++;
        $display("FAIL reset_in_resp: cycle %0d got val=%b rdy=%b sum=%h chk=%h flags=%b%b%b, want 0 1 all zero",
                 c, a_rval, a_rdy, a_sum, a_chk, a_ok, a_lerr, a_terr);
      end
    end
    good_pkt_a();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_data = '0; a_keep = '0; a_val = 1'b0; a_last = 1'b0; a_rrdy = 1'b0;
    b_data = '0; b_keep = '0; b_val = 1'b0; b_last = 1'b0; b_rrdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_bad_chksum_drain();
    test_ihl6_w64();
    test_len_err();
    test_trunc_w64();
    test_max_ihl();
    test_reset_in_resp();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d/%0d pending verdicts, want 0/0", sb_a.size(), sb_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
